// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: registered N-to-1 valid/ready mux with run-time selectable
// fixed-priority or round-robin arbitration and 1-cycle latency.
module mux_nto1_rr #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_sel,
    input  logic             out_ready
);
    logic          load;
    logic          found;
    logic [SW-1:0] g;
    logic [SW-1:0] ptr;
    int            idx;

    assign load = !out_valid || out_ready;

    // Scan channels starting at ptr (round-robin) or at 0 (fixed priority).
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = mode ? (i + int'(ptr)) % N : i;
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                g     = idx[SW-1:0];
            end
        end
    end

    assign in_ready = (rst_n && load && found) ? ({{(N-1){1'b0}}, 1'b1} << g) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(g)*W +: W];
                out_sel   <= g;
                if (mode)
                    ptr <= (g == SW'(N-1)) ? '0 : g + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
